// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load enables,
// flush/bubble control, operand forwarding selects and HI/LO multi-cycle tracking.
module pipeline_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] ID_RS,
  input  logic [4:0] ID_RT,
  input  logic       ID_USES_RS,
  input  logic       ID_USES_RT,
  input  logic       ID_BRANCH_TAKEN,
  input  logic       ID_MULDIV_START,
  input  logic       ID_MULDIV_IS_DIV,
  input  logic       ID_READS_HILO,
  input  logic [4:0] EX_REG,
  input  logic [4:0] MEM_REG,
  input  logic [4:0] WB_REG,
  input  logic       EX_RF_ENABLE,
  input  logic       MEM_RF_ENABLE,
  input  logic       WB_RF_ENABLE,
  input  logic       EX_LOAD_INSTR,
  output logic       PC_LE,
  output logic       IF_ID_LE,
  output logic       IF_ID_FLUSH,
  output logic       ID_EX_BUBBLE,
  output logic [1:0] FWD_A,
  output logic [1:0] FWD_B,
  output logic       MULDIV_BUSY,
  output logic       MULDIV_DONE
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 32'd1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 32'd1);

  state_t     state_r, state_nxt_s;
  logic [5:0] cnt_r, cnt_nxt_s;
  logic       busy_s, load_use_s, hilo_stall_s, stall_s;

  // Youngest producing stage wins, so EX is checked before MEM before WB.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       uses,
    input logic [4:0] ex_reg,
    input logic       ex_en,
    input logic [4:0] mem_reg,
    input logic       mem_en,
    input logic [4:0] wb_reg,
    input logic       wb_en
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (uses && (src != 5'd0)) begin
      if (ex_en && (ex_reg == src)) begin
        sel = 2'b01;
      end else if (mem_en && (mem_reg == src)) begin
        sel = 2'b10;
      end else if (wb_en && (wb_reg == src)) begin
        sel = 2'b11;
      end else begin
        sel = 2'b00;
      end
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign busy_s       = (state_r == BUSY);
  assign load_use_s   = EX_LOAD_INSTR && EX_RF_ENABLE && (EX_REG != 5'd0) &&
                        ((ID_USES_RS && (EX_REG == ID_RS)) ||
                         (ID_USES_RT && (EX_REG == ID_RT)));
  assign hilo_stall_s = busy_s && (ID_READS_HILO || ID_MULDIV_START);
  assign stall_s      = load_use_s || hilo_stall_s;

  // HI/LO unit state and occupancy counter register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
      cnt_r   <= 6'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: a start is only accepted when the instruction actually leaves ID.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (ID_MULDIV_START && !stall_s) begin
          cnt_nxt_s   = ID_MULDIV_IS_DIV ? DIV_LOAD : MUL_LOAD;
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r != 6'd0) begin
          cnt_nxt_s = cnt_r - 6'd1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 6'd0;
      end
    endcase
  end

  // Pipeline controls; held in their safe values while reset is asserted.
  always_comb begin
    PC_LE        = 1'b0;
    IF_ID_LE     = 1'b0;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_BUBBLE = 1'b1;
    FWD_A        = 2'b00;
    FWD_B        = 2'b00;
    MULDIV_BUSY  = 1'b0;
    MULDIV_DONE  = 1'b0;
    if (Reset) begin
      PC_LE        = !stall_s;
      IF_ID_LE     = !stall_s;
      ID_EX_BUBBLE = stall_s;
      IF_ID_FLUSH  = ID_BRANCH_TAKEN && !stall_s;
      FWD_A        = fwd_sel(ID_RS, ID_USES_RS, EX_REG, EX_RF_ENABLE,
                             MEM_REG, MEM_RF_ENABLE, WB_REG, WB_RF_ENABLE);
      FWD_B        = fwd_sel(ID_RT, ID_USES_RT, EX_REG, EX_RF_ENABLE,
                             MEM_REG, MEM_RF_ENABLE, WB_REG, WB_RF_ENABLE);
      MULDIV_BUSY  = busy_s;
      MULDIV_DONE  = busy_s && (cnt_r == 6'd0);
    end else begin
      MULDIV_BUSY  = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected control vectors are queued
// as stimulus is driven and compared against the DUT at the falling edge.
module tb_pipeline_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [4:0] id_rs, id_rt, ex_reg, mem_reg, wb_reg;
  logic       id_uses_rs, id_uses_rt, id_branch_taken, id_muldiv_start;
  logic       id_muldiv_is_div, id_reads_hilo;
  logic       ex_rf_enable, mem_rf_enable, wb_rf_enable, ex_load_instr;
  logic       pc_le, if_id_le, if_id_flush, id_ex_bubble, muldiv_busy, muldiv_done;
  logic [1:0] fwd_a, fwd_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] exp_q[$];
  logic [9:0] obs, exp_v;

  wire [9:0] out_v = {pc_le, if_id_le, if_id_flush, id_ex_bubble,
                      fwd_a, fwd_b, muldiv_busy, muldiv_done};

  pipeline_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .ID_RS(id_rs), .ID_RT(id_rt), .ID_USES_RS(id_uses_rs), .ID_USES_RT(id_uses_rt),
    .ID_BRANCH_TAKEN(id_branch_taken), .ID_MULDIV_START(id_muldiv_start),
    .ID_MULDIV_IS_DIV(id_muldiv_is_div), .ID_READS_HILO(id_reads_hilo),
    .EX_REG(ex_reg), .MEM_REG(mem_reg), .WB_REG(wb_reg),
    .EX_RF_ENABLE(ex_rf_enable), .MEM_RF_ENABLE(mem_rf_enable), .WB_RF_ENABLE(wb_rf_enable),
    .EX_LOAD_INSTR(ex_load_instr),
    .PC_LE(pc_le), .IF_ID_LE(if_id_le), .IF_ID_FLUSH(if_id_flush), .ID_EX_BUBBLE(id_ex_bubble),
    .FWD_A(fwd_a), .FWD_B(fwd_b), .MULDIV_BUSY(muldiv_busy), .MULDIV_DONE(muldiv_done)
  );

  always #5 Clk = ~Clk;

  function automatic logic [9:0] mk(input logic pc, input logic le, input logic fl,
                                    input logic bub, input logic [1:0] fa,
                                    input logic [1:0] fb, input logic busy,
                                    input logic done);
    return {pc, le, fl, bub, fa, fb, busy, done};
  endfunction

  localparam logic [9:0] RST_V  = 10'b0001_0000_00;
  localparam logic [9:0] NORM_V = 10'b1100_0000_00;

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_branch_taken = 1'b0; id_muldiv_start = 1'b0; id_muldiv_is_div = 1'b0;
    id_reads_hilo = 1'b0; ex_reg = 5'd0; mem_reg = 5'd0; wb_reg = 5'd0;
    ex_rf_enable = 1'b0; mem_rf_enable = 1'b0; wb_rf_enable = 1'b0; ex_load_instr = 1'b0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    id_rs = 5'd5; id_uses_rs = 1'b1; ex_reg = 5'd5; ex_rf_enable = 1'b1;
    id_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(RST_V);
      @(negedge Clk);
      obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs, exp_v);
      end
      tick();
    end
    Reset = 1'b1;
    clear_inputs();
    exp_q.push_back(NORM_V);
    @(negedge Clk);
    obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b", obs, exp_v);
    end
    tick();
  endtask

  typedef struct {
    logic [4:0] rs, rt; logic urs, urt;
    logic [4:0] ex; logic exen; logic [4:0] mem; logic memen; logic [4:0] wb; logic wben;
    logic [1:0] fa, fb;
  } fwd_vec_t;

  task automatic test_forwarding();
    fwd_vec_t tbl[6];
    tbl[0] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 2'b01, 2'b00};
    tbl[1] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 2'b10, 2'b00};
    tbl[2] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 2'b00};
    tbl[3] = '{5'd0, 5'd9, 1'b0, 1'b1, 5'd4, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 2'b00, 2'b11};
    tbl[4] = '{5'd0, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 2'b00, 2'b00};
    tbl[5] = '{5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 2'b10, 2'b10};
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      id_rs = tbl[i].rs; id_rt = tbl[i].rt; id_uses_rs = tbl[i].urs; id_uses_rt = tbl[i].urt;
      ex_reg = tbl[i].ex; ex_rf_enable = tbl[i].exen;
      mem_reg = tbl[i].mem; mem_rf_enable = tbl[i].memen;
      wb_reg = tbl[i].wb; wb_rf_enable = tbl[i].wben;
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, tbl[i].fa, tbl[i].fb, 1'b0, 1'b0));
      @(negedge Clk);
      obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL fwd[%0d]: got %b expected %b", i, obs, exp_v);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_load_instr = 1'b1; ex_reg = 5'd8; ex_rf_enable = 1'b1; id_rt = 5'd8; id_uses_rt = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0));
    @(negedge Clk);
    obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL load_use_stall: got %b expected %b", obs, exp_v);
    end
    tick();
    // Load advanced to MEM, bubble now in EX.
    ex_load_instr = 1'b0; ex_reg = 5'd0; ex_rf_enable = 1'b0; mem_reg = 5'd8; mem_rf_enable = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0));
    @(negedge Clk);
    obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL load_use_release: got %b expected %b", obs, exp_v);
    end
    tick();
    clear_inputs();
    ex_load_instr = 1'b1; ex_reg = 5'd0; ex_rf_enable = 1'b1; id_uses_rs = 1'b1;
    exp_q.push_back(NORM_V);
    @(negedge Clk);
    obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL load_use_r0: got %b expected %b", obs, exp_v);
    end
    tick();
    clear_inputs();
    ex_load_instr = 1'b1; ex_reg = 5'd8; ex_rf_enable = 1'b1; id_rt = 5'd8;
    exp_q.push_back(NORM_V);
    @(negedge Clk);
    obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL load_use_unused: got %b expected %b", obs, exp_v);
    end
    tick();
    id_rt = 5'd0; id_rs = 5'd8; id_uses_rs = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0));
    @(negedge Clk);
    obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL load_use_rs: got %b expected %b", obs, exp_v);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_branch_stall();
    clear_inputs();
    ex_load_instr = 1'b1; ex_reg = 5'd8; ex_rf_enable = 1'b1; id_rs = 5'd8; id_uses_rs = 1'b1;
    id_branch_taken = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0));
    @(negedge Clk);
    obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL branch_under_stall: got %b expected %b", obs, exp_v);
    end
    tick();
    ex_load_instr = 1'b0; ex_reg = 5'd0; ex_rf_enable = 1'b0; mem_reg = 5'd8; mem_rf_enable = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0));
    @(negedge Clk);
    obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL branch_after_stall: got %b expected %b", obs, exp_v);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_muldiv(input logic is_div, input int n);
    clear_inputs();
    id_muldiv_start = 1'b1; id_muldiv_is_div = is_div;
    exp_q.push_back(NORM_V);
    @(negedge Clk);
    obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL md_start(div=%0d): got %b expected %b", is_div, obs, exp_v);
    end
    tick();
    id_muldiv_start = 1'b0; id_reads_hilo = 1'b1;
    for (int k = 1; k <= n; k++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, (k == n)));
      @(negedge Clk);
      obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL md_busy(div=%0d,cyc=%0d): got %b expected %b", is_div, k, obs, exp_v);
      end
      tick();
    end
    exp_q.push_back(NORM_V);
    @(negedge Clk);
    obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL md_hilo_issue(div=%0d): got %b expected %b", is_div, obs, exp_v);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    id_muldiv_start = 1'b1;
    exp_q.push_back(NORM_V);
    @(negedge Clk);
    obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_first: got %b expected %b", obs, exp_v);
    end
    tick();
    // Second MULT held in ID until the unit returns to IDLE.
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, (k == 4)));
      else        exp_q.push_back(NORM_V);
      @(negedge Clk);
      obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_hold(cyc=%0d): got %b expected %b", k, obs, exp_v);
      end
      tick();
    end
    id_muldiv_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, (k <= 4), (k == 4)));
      @(negedge Clk);
      obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_second(cyc=%0d): got %b expected %b", k, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_busy();
    clear_inputs();
    id_muldiv_start = 1'b1; id_muldiv_is_div = 1'b1;
    tick();
    id_muldiv_start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0));
      @(negedge Clk);
      obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rst_mid_busy(cyc=%0d): got %b expected %b", k, obs, exp_v);
      end
      tick();
    end
    #1;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0));
    obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL rst_mid_cyc7: got %b expected %b", obs, exp_v);
    end
    Reset = 1'b0;
    #1;
    exp_q.push_back(RST_V);
    obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL rst_mid_abort: got %b expected %b", obs, exp_v);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(RST_V);
      @(negedge Clk);
      obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rst_mid_hold[%0d]: got %b expected %b", i, obs, exp_v);
      end
      tick();
    end
    Reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(NORM_V);
      @(negedge Clk);
      obs = out_v; exp_v = exp_q.pop_front(); n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rst_mid_idle[%0d]: got %b expected %b", i, obs, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_stall();
    test_muldiv(1'b1, 16);
    test_muldiv(1'b0, 4);
    test_back_to_back();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates PC/IF-ID load enables, IF/ID flush, ID/EX bubble insertion and operand-forwarding selects.
- Tracks a multi-cycle HI/LO multiply/divide unit with a cycle counter and stalls dependent instructions.
- Sits beside the decode stage; all pipeline registers take their LE/Reset/bubble controls from it.

Parameters:
- MUL_CYCLES, 4, EX-occupancy cycles of MULT/MULTU (≥2).
- DIV_CYCLES, 16, EX-occupancy cycles of DIV/DIVU (≥2, ≤63).

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ID_RS, ID_RT  in  5 each  source register numbers of the instruction in ID.
- ID_USES_RS, ID_USES_RT  in  1 each  instruction in ID reads RS / RT.
- ID_BRANCH_TAKEN  in  1  branch/jump resolved taken in ID.
- ID_MULDIV_START  in  1  instruction in ID is MULT/MULTU/DIV/DIVU.
- ID_MULDIV_IS_DIV  in  1  qualifies START: 1=divide, 0=multiply.
- ID_READS_HILO  in  1  instruction in ID is MFHI/MFLO.
- EX_REG, MEM_REG, WB_REG  in  5 each  destination register in that stage.
- EX_RF_ENABLE, MEM_RF_ENABLE, WB_RF_ENABLE  in  1 each  stage will write the register file.
- EX_LOAD_INSTR  in  1  instruction in EX is a load.
- PC_LE  out  1  PC load enable.
- IF_ID_LE  out  1  IF/ID register load enable.
- IF_ID_FLUSH  out  1  IF/ID register clears to NOP next edge.
- ID_EX_BUBBLE  out  1  ID/EX control fields load zeros next edge.
- FWD_A, FWD_B  out  2 each  operand source: 00 RF, 01 EX result, 10 MEM result, 11 WB result.
- MULDIV_BUSY  out  1  HI/LO unit occupied.
- MULDIV_DONE  out  1  one-cycle pulse on the last busy cycle.

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE, counter 0, MULDIV_DONE=0. While reset is asserted: PC_LE=0, IF_ID_LE=0, IF_ID_FLUSH=0, ID_EX_BUBBLE=1, FWD_A=FWD_B=00, MULDIV_BUSY=0. Normal operation resumes on the first rising edge after deassertion.
- Forwarding (combinational):
  - For RS (A) and RT (B) independently, use the first matching stage in the order EX→01, MEM→10, WB→11.
  - Match condition: stage RF_ENABLE=1, stage reg == source reg, source reg ≠ 0, and the matching USES bit = 1.
  - Otherwise 00.
- Load-use hazard (load_use):
  - Asserted when EX_LOAD_INSTR=1, EX_RF_ENABLE=1, EX_REG≠0, and EX_REG equals a used RS or RT.
  - Exactly a one-cycle stall. Next cycle the load is in MEM and forwards via 10.
- HI/LO hazard (hilo_stall): MULDIV_BUSY=1 and (ID_READS_HILO or ID_MULDIV_START).
- stall = load_use | hilo_stall. When stall=1: PC_LE=0, IF_ID_LE=0, ID_EX_BUBBLE=1, IF_ID_FLUSH=0. When stall=0: PC_LE=1, IF_ID_LE=1, ID_EX_BUBBLE=0.
- Flush: IF_ID_FLUSH = ID_BRANCH_TAKEN & ~stall. A taken branch under stall is held in ID and takes effect on the first unstalled cycle. The delay slot is not flushed by the pipeline; flush applies to the wrong-path fetch only.
- FSM, 2 states, registered:
  - IDLE: if ID_MULDIV_START & ~stall, load cnt = (IS_DIV ? DIV_CYCLES : MUL_CYCLES) − 1 and go to BUSY.
  - BUSY: MULDIV_BUSY=1.
    - cnt≠0: decrement.
    - cnt==0: MULDIV_DONE=1 for that cycle, go to IDLE. In that cycle MULDIV_BUSY is still 1, so dependent instructions issue the following cycle.
- A START in ID during BUSY is stalled, and is accepted on the cycle after return to IDLE.
- Counter is 6 bits. No wrap: decrement only when ≠0.
- Reset mid-BUSY aborts the operation immediately, with no DONE pulse.

Test Plan:
- Reset low 3 cycles, release → PC_LE=IF_ID_LE=1, ID_EX_BUBBLE=0, FWD=00, MULDIV_BUSY=0.
- ID_RS=5 used, EX_REG=5 RF_EN, MEM_REG=5 RF_EN → FWD_A=01. With EX_RF_ENABLE=0 → FWD_A=10. ID_RS=0 with all stages targeting reg 0 → FWD_A=00.
- Load in EX to reg 8, ID_RT=8 used → one cycle PC_LE=0, IF_ID_LE=0, ID_EX_BUBBLE=1. Next cycle (MEM_REG=8) → no stall, FWD_B=10.
- DIV start accepted → MULDIV_BUSY high exactly 16 cycles, DONE pulse on 16th. MFLO in ID during busy stalls until the cycle after DONE. With MUL, busy lasts 4 cycles.
- ID_BRANCH_TAKEN=1 coinciding with load-use stall → IF_ID_FLUSH=0 that cycle, =1 next cycle.
- Reset asserted at busy cycle 7 of DIV → MULDIV_BUSY=0 immediately, no DONE pulse, state IDLE after release.
